// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 keyboard event path: prefix bytes,
// discard list, decoder state encoding and the 10-bit event record.
package kb_pkg;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  // Keyboard status/response bytes that never become key events.
  localparam int N_DISCARD = 6;
  localparam logic [N_DISCARD-1:0][7:0] DISCARD_CODES =
    {8'hFF, 8'h00, 8'hFE, 8'hEE, 8'hFA, 8'hAA};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } kb_state_e;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_evt_t;

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++) begin
      if (b == DISCARD_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == BRK_CODE) || (b == EXT_CODE);
  endfunction

endpackage

// File: rtl/kb_event_buf.sv
// First-word-fall-through event FIFO with extra-MSB pointers and a sticky
// overflow flag for writes dropped while full.
module kb_event_buf #(
  parameter int DEPTH_LOG2 = 2,
  parameter int DW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          ovf_clr,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          wr_ok, rd_ok;
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  // A pop frees the head slot at the same edge, so write-while-full succeeds.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    rd_ok      = rd_en && !empty;
    wr_ok      = wr_en && (!full || rd_ok);
    wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, wr_ok};
    rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, rd_ok};
    overflow_d = (overflow_q && !ovf_clr) || (wr_en && !wr_ok);
    rd_data    = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    overflow   = overflow_q;
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 serial receiver: filters ps2c, shifts 11-bit frames on falling edges and
// pulses rx_done_tick for one cycle with the data byte on dout.
module ps2_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout
);

  typedef enum logic [1:0] {RX_IDLE, RX_DPS, RX_LOAD} rx_state_e;

  rx_state_e   state_q, state_d;
  logic [7:0]  filter_q, filter_d;
  logic        f_ps2c_q, f_ps2c_d;
  logic [3:0]  n_q, n_d;
  logic [10:0] b_q, b_d;
  logic        fall_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
      n_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
      n_q      <= n_d;
      b_q      <= b_d;
    end
  end

  always_comb begin
    filter_d = {ps2c, filter_q[7:1]};
    f_ps2c_d = f_ps2c_q;
    if (&filter_q)       f_ps2c_d = 1'b1;
    else if (~|filter_q) f_ps2c_d = 1'b0;
    fall_edge = f_ps2c_q & ~f_ps2c_d;
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    unique case (state_q)
      RX_IDLE: if (fall_edge && rx_en) begin
        b_d     = {ps2d, b_q[10:1]};
        n_d     = 4'd9;
        state_d = RX_DPS;
      end
      RX_DPS: if (fall_edge) begin
        b_d = {ps2d, b_q[10:1]};
        if (n_q == 4'd0) state_d = RX_LOAD;
        else             n_d = n_q - 4'd1;
      end
      RX_LOAD: state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  // Frames with a bad start/stop bit or even parity are silently dropped.
  always_comb begin
    rx_done_tick = (state_q == RX_LOAD) && !b_q[0] && b_q[10] && (^b_q[9:1]);
    dout         = b_q[8:1];
  end

endmodule

// File: rtl/kb_event_fifo.sv
// PS/2 scan-code decoder feeding a key event FIFO. Define KB_MAKE_EVT_EN to
// enqueue make events; by default only break (release) events are queued.
module kb_event_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       key_rd,
  input  logic       ovf_clr,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  output logic       fifo_full,
  output logic       overflow
);

`ifdef KB_MAKE_EVT_EN
  localparam logic MAKE_EN = 1'b1;
`else
  localparam logic MAKE_EN = 1'b0;
`endif

  kb_state_e  state_q, state_d;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       evt_wr;
  kb_evt_t    evt_data;
  kb_evt_t    head;
  logic       buf_empty;

  ps2_rx u_rx (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rx_en        (1'b1),
    .rx_done_tick (rx_done),
    .dout         (rx_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_done) begin
      unique case (state_q)
        S_IDLE:    if (rx_byte == EXT_CODE)      state_d = S_EXT;
                   else if (rx_byte == BRK_CODE) state_d = S_BRK;
        S_EXT:     if (rx_byte == BRK_CODE)      state_d = S_EXT_BRK;
                   else if (rx_byte != EXT_CODE) state_d = S_IDLE;
        S_BRK:     if (!is_prefix(rx_byte))      state_d = S_IDLE;
        S_EXT_BRK: if (!is_prefix(rx_byte))      state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Events are emitted on the done tick that completes a sequence.
  always_comb begin
    evt_wr        = 1'b0;
    evt_data      = '0;
    evt_data.code = rx_byte;
    if (rx_done) begin
      unique case (state_q)
        S_IDLE: if (!is_prefix(rx_byte) && !is_discard(rx_byte)) evt_wr = MAKE_EN;
        S_EXT: if (!is_prefix(rx_byte)) begin
          evt_wr       = MAKE_EN;
          evt_data.ext = 1'b1;
        end
        S_BRK: if (!is_prefix(rx_byte)) begin
          evt_wr       = 1'b1;
          evt_data.brk = 1'b1;
        end
        S_EXT_BRK: if (!is_prefix(rx_byte)) begin
          evt_wr       = 1'b1;
          evt_data.ext = 1'b1;
          evt_data.brk = 1'b1;
        end
        default: evt_wr = 1'b0;
      endcase
    end
  end

  kb_event_buf #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DW         (EVT_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (evt_wr),
    .wr_data  (evt_data),
    .rd_en    (key_rd),
    .ovf_clr  (ovf_clr),
    .rd_data  (head),
    .empty    (buf_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

  always_comb begin
    key_valid = !buf_empty;
    key_code  = head.code;
    key_ext   = head.ext;
    key_brk   = head.brk;
  end

endmodule
